// File: rtl/cnn_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : cnn_result_collector
// Brief    : Joins NUM_OUT AXI-Stream CNN output words into one wide result beat.
//            Optional macro CNN_RESULT_COLLECTOR_ARGMAX_EN adds signed argmax/max outputs.
// Revision : 1.0  initial release
// ============================================================================
module cnn_result_collector #(
    parameter int PIXEL_BIT_WIDTH = 16,
    parameter int NUM_OUT         = 5
) (
    input  logic                               ap_clk,
    input  logic                               ap_rst,
    input  logic [NUM_OUT*PIXEL_BIT_WIDTH-1:0] cnn_output_TDATA,
    input  logic [NUM_OUT-1:0]                 cnn_output_TVALID,
    output logic [NUM_OUT-1:0]                 cnn_output_TREADY,
    output logic [NUM_OUT*PIXEL_BIT_WIDTH-1:0] result_TDATA,
    output logic                               result_TVALID,
    input  logic                               result_TREADY,
`ifdef CNN_RESULT_COLLECTOR_ARGMAX_EN
    output logic [2:0]                         result_argmax,
    output logic [PIXEL_BIT_WIDTH-1:0]         result_max,
`endif
    output logic [15:0]                        frame_count
);

    localparam int W  = PIXEL_BIT_WIDTH;
    localparam int DW = NUM_OUT * PIXEL_BIT_WIDTH;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_OUT-1:0] full_q, full_d;
    logic [NUM_OUT-1:0] ready_q, ready_d;
    logic [NUM_OUT-1:0] fire;
    logic [DW-1:0]      slot_q, slot_d;
    logic [15:0]        count_q, count_d;

    always_comb begin
        fire    = cnn_output_TVALID & ready_q;
        full_d  = full_q | fire;
        slot_d  = slot_q;
        state_d = state_q;
        count_d = count_q;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (fire[k]) begin
                slot_d[k*W +: W] = cnn_output_TDATA[k*W +: W];
            end
        end
        case (state_q)
            COLLECT: begin
                if (&full_d) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (result_TREADY) begin
                    state_d = COLLECT;
                    full_d  = '0;
                    count_d = count_q + 16'd1;
                end
            end
            default: state_d = COLLECT;
        endcase
        // Ready is registered from the next state so it stays low throughout reset.
        ready_d = (state_d == COLLECT) ? ~full_d : '0;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= COLLECT;
            full_q  <= '0;
            ready_q <= '0;
            slot_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
            ready_q <= ready_d;
            slot_q  <= slot_d;
            count_q <= count_d;
        end
    end

    assign cnn_output_TREADY = ready_q;
    assign result_TDATA      = slot_q;
    assign result_TVALID     = (state_q == EMIT);
    assign frame_count       = count_q;

`ifdef CNN_RESULT_COLLECTOR_ARGMAX_EN
    logic [2:0]          amax_idx;
    logic signed [W-1:0] amax_val;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        amax_idx = '0;
        amax_val = slot_q[0 +: W];
        for (int k = 1; k < NUM_OUT; k++) begin
            if ($signed(slot_q[k*W +: W]) > amax_val) begin
                amax_val = slot_q[k*W +: W];
                amax_idx = 3'(k);
            end
        end
    end

    assign result_argmax = amax_idx;
    assign result_max    = amax_val;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cnn_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_result_collector
// Brief    : Directed and randomized self-checking bench for cnn_result_collector.
// Revision : 1.0  initial release
// ============================================================================
module tb_cnn_result_collector;

    localparam int W  = 16;
    localparam int N  = 5;
    localparam int DW = W * N;

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b1;
    logic [DW-1:0] tdata  = '0;
    logic [N-1:0]  tvalid = '0;
    logic [N-1:0]  tready;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rready = 1'b0;
    logic [15:0]   fcount;
`ifdef CNN_RESULT_COLLECTOR_ARGMAX_EN
    logic [2:0]    amax;
    logic [W-1:0]  mval;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 ap_clk = ~ap_clk;

    cnn_result_collector #(
        .PIXEL_BIT_WIDTH (W),
        .NUM_OUT         (N)
    ) dut (
        .ap_clk            (ap_clk),
        .ap_rst            (ap_rst),
        .cnn_output_TDATA  (tdata),
        .cnn_output_TVALID (tvalid),
        .cnn_output_TREADY (tready),
        .result_TDATA      (rdata),
        .result_TVALID     (rvalid),
        .result_TREADY     (rready),
`ifdef CNN_RESULT_COLLECTOR_ARGMAX_EN
        .result_argmax     (amax),
        .result_max        (mval),
`endif
        .frame_count       (fcount)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset;
        ap_rst = 1'b1;
        tvalid = '0;
        rready = 1'b0;
        tdata  = '0;
        tick;
        tick;
        ap_rst = 1'b0;
        tick;
    endtask

    initial begin
        int            order [N];
        logic [DW-1:0] exp_t2;
        logic [W-1:0]  expq [N][$];
        logic [N-1:0]  acc;
        logic [DW-1:0] e;
        bit            slow;
        int            results;
        int            cycles;

        // Reset state
        tick;
        tick;
        check("rst_tready", 128'(tready), 128'(0));
        check("rst_tvalid", 128'(rvalid), 128'(0));
        check("rst_fcount", 128'(fcount), 128'(0));
        check("rst_tdata",  128'(rdata),  128'(0));
`ifdef CNN_RESULT_COLLECTOR_ARGMAX_EN
        check("rst_argmax", 128'(amax), 128'(0));
        check("rst_max",    128'(mval), 128'(0));
`endif
        ap_rst = 1'b0;
        tick;
        check("post_rst_tready", 128'(tready), 128'(5'h1f));

        // All five streams in one cycle
        tvalid = '1;
        tdata  = {16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        tick;
        tvalid = '0;
        check("t1_valid",  128'(rvalid), 128'(1));
        check("t1_data",   128'(rdata),  128'(80'h0005_0004_0003_0002_0001));
        check("t1_tready", 128'(tready), 128'(0));
        rready = 1'b1;
        tick;
        rready = 1'b0;
        check("t1_hs_valid",    128'(rvalid), 128'(0));
        check("t1_fcount",      128'(fcount), 128'(1));
        check("t1_tready_back", 128'(tready), 128'(5'h1f));

        // One stream per cycle in order 4,2,0,3,1, then a long stall
        do_reset;
        order  = '{4, 2, 0, 3, 1};
        exp_t2 = {16'hA004, 16'hA003, 16'hA002, 16'hA001, 16'hA000};
        tdata  = exp_t2;
        for (int i = 0; i < N; i++) begin
            tvalid = 5'(1 << order[i]);
            tick;
            if (i == N - 2) check("t2_partial_valid", 128'(rvalid), 128'(0));
        end
        tvalid = '0;
        tdata  = {$urandom, $urandom, $urandom};
        check("t2_valid", 128'(rvalid), 128'(1));
        check("t2_data",  128'(rdata),  128'(exp_t2));
        for (int i = 0; i < 20; i++) begin
            tick;
            check("t2_hold_valid", 128'(rvalid), 128'(1));
            check("t2_hold_data",  128'(rdata),  128'(exp_t2));
        end
        rready = 1'b1;
        tick;
        rready = 1'b0;
        check("t2_hs_valid", 128'(rvalid), 128'(0));
        check("t2_fcount",   128'(fcount), 128'(1));
        tick;
        tick;
        check("t2_single_fcount", 128'(fcount), 128'(1));

        // Stream 0 changes data while its slot is already full
        do_reset;
        tvalid = 5'h01;
        tdata  = 80'h00AA;
        tick;
        tdata  = 80'h00BB;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("t3_tready_stall", 128'(tready), 128'(5'h1e));
        end
        tvalid = 5'h1f;
        tdata  = {16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h00BB};
        tick;
        tvalid = '0;
        check("t3_valid",  128'(rvalid),     128'(1));
        check("t3_slot0",  128'(rdata[15:0]), 128'(16'h00AA));
        check("t3_tready", 128'(tready),     128'(0));
        rready = 1'b1;
        tick;
        rready = 1'b0;
        check("t3_tready_back", 128'(tready), 128'(5'h1f));

        // Reset after three of five slots filled
        do_reset;
        tvalid = 5'h07;
        tdata  = {$urandom, $urandom, $urandom};
        tick;
        tvalid = '0;
        check("t4_partial_tready", 128'(tready), 128'(5'h18));
        ap_rst = 1'b1;
        tick;
        check("t4_rst_tready", 128'(tready), 128'(0));
        ap_rst = 1'b0;
        tick;
        check("t4_tready", 128'(tready), 128'(5'h1f));
        check("t4_fcount", 128'(fcount), 128'(0));
        check("t4_valid",  128'(rvalid), 128'(0));
        tvalid = 5'h18;
        tick;
        tvalid = '0;
        check("t4_no_emit",   128'(rvalid), 128'(0));
        check("t4_remaining", 128'(tready), 128'(5'h07));

`ifdef CNN_RESULT_COLLECTOR_ARGMAX_EN
        do_reset;
        tvalid = '1;
        tdata  = {16'h0003, 16'h8000, 16'h0007, 16'h0007, 16'hFFF0};
        tick;
        tvalid = '0;
        check("am_argmax", 128'(amax), 128'(1));
        check("am_max",    128'(mval), 128'(16'h0007));
        rready = 1'b1;
        tick;
        rready = 1'b0;
`endif

        // Randomized traffic against a per-stream FIFO reference model
        do_reset;
        results = 0;
        cycles  = 0;
        while (results < 70000 && cycles < 400000) begin
            acc = tvalid & tready;
            for (int k = 0; k < N; k++) begin
                if (acc[k]) expq[k].push_back(tdata[k*W +: W]);
            end
            if (rvalid && rready) begin
                for (int k = 0; k < N; k++) begin
                    if (expq[k].size() > 0) e[k*W +: W] = expq[k].pop_front();
                    else                    e[k*W +: W] = 'x;
                end
                check("rand_data", 128'(rdata), 128'(e));
                results++;
            end
            slow = (results < 3000);
            tick;
            cycles++;
            for (int k = 0; k < N; k++) begin
                if (!tvalid[k] || acc[k]) begin
                    tvalid[k]        = slow ? 1'($urandom_range(0, 1)) : 1'b1;
                    tdata[k*W +: W]  = W'($urandom);
                end
            end
            rready = slow ? ($urandom_range(0, 9) < 6) : 1'b1;
        end
        tvalid = '0;
        rready = 1'b0;
        check("rand_results", 128'(results), 128'(70000));
        // 70000 mod 65536
        check("rand_wrap", 128'(fcount), 128'(4464));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
